// File: rtl/alu_cu_pkg.sv
// alu_cu_pkg -- shared encodings for the ALU control unit.
//   alu_op class encodings, {funct7[5], funct3} operation codes, and the
//   internal operation enum passed from the decoder to the datapath.
package alu_cu_pkg;

  // Main-decoder op class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // load/store address
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // decode funct field
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  // {funct7[5], funct3[2:0]}
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b1000;
  localparam logic [3:0] FN_AND  = 4'b0111;
  localparam logic [3:0] FN_OR   = 4'b0110;
  localparam logic [3:0] FN_XOR  = 4'b0100;
  localparam logic [3:0] FN_SLL  = 4'b0001;
  localparam logic [3:0] FN_SRL  = 4'b0101;
  localparam logic [3:0] FN_SRA  = 4'b1101;
  localparam logic [3:0] FN_SLT  = 4'b0010;
  localparam logic [3:0] FN_SLTU = 4'b0011;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU
  } alu_oper_e;

endpackage

// File: rtl/alu_cu_decode.sv
// alu_cu_decode -- combinational alu_op/funct decoder.
//   Ports: alu_op [1:0] op class, funct [3:0] operation field,
//          op (alu_oper_e) selected operation, illegal unsupported combination.
//   Build option: ALU_CU_SHIFT_EN enables sll/srl/sra; without it those
//   funct codes decode as illegal.
module alu_cu_decode
  import alu_cu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [3:0] funct,
  output alu_oper_e  op,
  output logic       illegal
);

  always_comb begin
    op      = OP_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_SLT:  op = OP_SLT;
          FN_SLTU: op = OP_SLTU;
`ifdef ALU_CU_SHIFT_EN
          FN_SLL:  op = OP_SLL;
          FN_SRL:  op = OP_SRL;
          FN_SRA:  op = OP_SRA;
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_cu.sv
// alu_cu -- ALU with integrated control decode, one-cycle registered output.
//   Ports: clk, rst_n (async, active-low), in_valid, a/b operands [WIDTH],
//          funct [3:0], alu_op [1:0];
//          out_valid, result [WIDTH], cout, zero, overflow, illegal.
//   Outputs load only on cycles with in_valid=1 and hold otherwise.
//   Build option: ALU_CU_SHIFT_EN enables the sll/srl/sra operations.
module alu_cu
  import alu_cu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       funct,
  input  logic [1:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  alu_oper_e op;
  logic      ill_p0;

  alu_cu_decode u_decode (
    .alu_op  (alu_op),
    .funct   (funct),
    .op      (op),
    .illegal (ill_p0)
  );

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] b_op;
  logic        [WIDTH:0]   sum;
  logic                    is_sub;

  assign a_s    = a;
  assign b_s    = b;
  assign is_sub = (op == OP_SUB);
  // Subtract as a + ~b + 1 so one adder gives both carry and no-borrow.
  assign b_op   = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};

`ifdef ALU_CU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);
  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];
`endif

  logic [WIDTH-1:0] res_p0;
  logic             cout_p0, ovf_p0, zero_p0;

  always_comb begin
    res_p0  = '0;
    cout_p0 = 1'b0;
    ovf_p0  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        res_p0  = sum[WIDTH-1:0];
        cout_p0 = sum[WIDTH];
        // Same-sign effective operands producing a different-sign sum.
        ovf_p0  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_p0 = a & b;
      OP_OR:   res_p0 = a | b;
      OP_XOR:  res_p0 = a ^ b;
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_CU_SHIFT_EN
      OP_SLL:  res_p0 = a << shamt;
      OP_SRL:  res_p0 = a >> shamt;
      OP_SRA:  res_p0 = a_s >>> shamt;
`endif
      default: res_p0 = '0;
    endcase
    if (ill_p0) begin
      res_p0  = '0;
      cout_p0 = 1'b0;
      ovf_p0  = 1'b0;
    end
    zero_p0 = (res_p0 == '0);
  end

  // ---- stage p0 -> p1: output registers ----
  logic             vld_p1;
  logic [WIDTH-1:0] res_p1;
  logic             cout_p1, zero_p1, ovf_p1, ill_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      res_p1  <= '0;
      cout_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
      ill_p1  <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        res_p1  <= res_p0;
        cout_p1 <= cout_p0;
        zero_p1 <= zero_p0;
        ovf_p1  <= ovf_p0;
        ill_p1  <= ill_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign result    = res_p1;
  assign cout      = cout_p1;
  assign zero      = zero_p1;
  assign overflow  = ovf_p1;
  assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_cu.sv
// tb_alu_cu -- directed bench for alu_cu (WIDTH=64) with an expected-result
// queue filled as each operation is driven and drained one cycle later.
// Shift expectations follow ALU_CU_SHIFT_EN when it is defined for the build.
module tb_alu_cu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   funct = '0;
  logic [1:0]   alu_op = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         cout, zero, overflow, illegal;

  alu_cu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .funct(funct), .alu_op(alu_op), .out_valid(out_valid), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        tag;
    logic [W-1:0] r;
    logic         c, z, o, i;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   total = 0;
  int   fails = 0;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic [W-1:0] r,
                              input logic c, input logic z, input logic o, input logic i);
    exp_t e;
    e.tag = tag; e.r = r; e.c = c; e.z = z; e.o = o; e.i = i;
    return e;
  endfunction

  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      total++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      e = q.pop_front();
      last = e;
      chk({e.tag, ".vld"},  {63'd0, out_valid}, 64'd1);
      chk({e.tag, ".res"},  result, e.r);
      chk({e.tag, ".cout"}, {63'd0, cout},     {63'd0, e.c});
      chk({e.tag, ".zero"}, {63'd0, zero},     {63'd0, e.z});
      chk({e.tag, ".ovf"},  {63'd0, overflow}, {63'd0, e.o});
      chk({e.tag, ".ill"},  {63'd0, illegal},  {63'd0, e.i});
    end
  endtask

  // Drive one operation at the falling edge, check it after the next rising edge.
  task automatic step(input logic [1:0] op, input logic [3:0] f,
                      input logic [W-1:0] aa, input logic [W-1:0] bb, input exp_t e);
    @(negedge clk);
    alu_op = op; funct = f; a = aa; b = bb; in_valid = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vld"},  {63'd0, out_valid}, 64'd0);
    chk({tag, ".res"},  result, 64'd0);
    chk({tag, ".cout"}, {63'd0, cout},     64'd0);
    chk({tag, ".zero"}, {63'd0, zero},     64'd0);
    chk({tag, ".ovf"},  {63'd0, overflow}, 64'd0);
    chk({tag, ".ill"},  {63'd0, illegal},  64'd0);
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    step(2'b10, 4'b0000, 64'd5, 64'd8, mk("add5_8", 64'd13, 0, 0, 0, 0));
    step(2'b01, 4'b0000, 64'd7, 64'd7, mk("sub7_7", 64'd0, 1, 1, 0, 0));
    step(2'b00, 4'b0000, MAXP, 64'd1, mk("addovf", MSB, 0, 0, 1, 0));
    step(2'b00, 4'b0000, ONES, 64'd1, mk("addwrap", 64'd0, 1, 1, 0, 0));
`ifdef ALU_CU_SHIFT_EN
    step(2'b10, 4'b1101, MSB, 64'd4, mk("sra", 64'hF800_0000_0000_0000, 0, 0, 0, 0));
    step(2'b10, 4'b0001, 64'd1, 64'd65, mk("sll", 64'd2, 0, 0, 0, 0));
    step(2'b10, 4'b0101, MSB, 64'd63, mk("srl", 64'd1, 0, 0, 0, 0));
`else
    step(2'b10, 4'b1101, MSB, 64'd4, mk("sra_ill", 64'd0, 0, 1, 0, 1));
    step(2'b10, 4'b0001, 64'd1, 64'd65, mk("sll_ill", 64'd0, 0, 1, 0, 1));
    step(2'b10, 4'b0101, MSB, 64'd63, mk("srl_ill", 64'd0, 0, 1, 0, 1));
`endif
    step(2'b11, 4'b0000, 64'd3, 64'd4, mk("aluop11", 64'd0, 0, 1, 0, 1));
    step(2'b10, 4'b0010, ONES, 64'd0, mk("slt", 64'd1, 0, 0, 0, 0));
    step(2'b10, 4'b0011, ONES, 64'd0, mk("sltu", 64'd0, 0, 1, 0, 0));
    step(2'b10, 4'b0111, 64'hF0F0, 64'hFF00, mk("and", 64'hF000, 0, 0, 0, 0));
    step(2'b10, 4'b0110, 64'hF0F0, 64'hFF00, mk("or", 64'hFFF0, 0, 0, 0, 0));
    step(2'b10, 4'b0100, 64'hF0F0, 64'hFF00, mk("xor", 64'h0FF0, 0, 0, 0, 0));
    step(2'b10, 4'b1000, 64'd3, 64'd5, mk("sub3_5", ONES - 64'd1, 0, 0, 0, 0));
    step(2'b01, 4'b0000, MSB, 64'd1, mk("subovf", MAXP, 1, 0, 1, 0));
    step(2'b10, 4'b1111, 64'd9, 64'd9, mk("fn1111", 64'd0, 0, 1, 0, 1));
    step(2'b10, 4'b0000, 64'd100, 64'd23, mk("add100", 64'd123, 0, 0, 0, 0));

    // Idle cycle: outputs hold, out_valid drops.
    @(negedge clk);
    in_valid = 1'b0; a = 64'd1; b = 64'd1;
    @(posedge clk);
    #1;
    chk("hold.vld", {63'd0, out_valid}, 64'd0);
    chk("hold.res", result, last.r);
    chk("hold.zero", {63'd0, zero}, {63'd0, last.z});

    // Reset pulse between edges with an operation being presented.
    @(negedge clk);
    alu_op = 2'b00; funct = 4'b0000; a = 64'd40; b = 64'd2; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rstasync");
    @(posedge clk);
    #1;
    chk("rstedge.vld", {63'd0, out_valid}, 64'd0);
    chk("rstedge.res", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst.vld", {63'd0, out_valid}, 64'd0);
    step(2'b00, 4'b0000, 64'd40, 64'd2, mk("postrst", 64'd42, 0, 0, 0, 0));

    @(negedge clk);
    in_valid = 1'b0;
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
